// File: rtl/bias_pkg.sv
// Shared types and sign-magnitude helpers for the bias/ReLU stage.
package bias_pkg;

  localparam int WIDTH = 16;
  localparam int CHANNELS = 64;

  typedef logic [WIDTH-1:0] sm_t;
  typedef logic signed [WIDTH:0] tc_t;

  localparam tc_t SAT_MAX = tc_t'((1 << (WIDTH-1)) - 1);

  function automatic tc_t sm_to_tc(input sm_t x);
    tc_t m;
    m = {2'b00, x[WIDTH-2:0]};
    return x[WIDTH-1] ? -m : m;
  endfunction

  // Negative results never produce a negative-zero encoding.
  function automatic sm_t tc_to_sm_sat(
    input tc_t v,
    input logic relu
  );
    tc_t a;
    a = (v < 0) ? -v : v;
    if (a > SAT_MAX) a = SAT_MAX;
    if (v < 0) return relu ? '0 : {1'b1, a[WIDTH-2:0]};
    return {1'b0, a[WIDTH-2:0]};
  endfunction

endpackage

// File: rtl/bias_relu_stage_sat.sv
// Saturate, optional ReLU and sign-magnitude re-encode of a biased sum.
module sm_sat_add
  import bias_pkg::*;
#(
  parameter bit RELU = 1'b1
) (
  input  tc_t sum,
  output sm_t res
);

  assign res = tc_to_sm_sat(sum, RELU);

endmodule

// File: rtl/bias_relu_stage.sv
// Two-stage streaming bias add with ReLU/saturation per output channel.
module bias_relu_stage
  import bias_pkg::*;
#(
  parameter int CHANNELS = bias_pkg::CHANNELS,
  parameter int WIDTH = bias_pkg::WIDTH,
  parameter bit RELU = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] bias_mem [0:CHANNELS-1],
  input  logic [WIDTH-1:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [$clog2(CHANNELS)-1:0] out_chan,
  output logic out_valid,
  input  logic out_ready,
  output logic pixel_done
);

  localparam int CW = $clog2(CHANNELS);
  localparam logic [CW-1:0] LAST = CW'(CHANNELS-1);

  logic [CW-1:0] chan;
  logic [CW-1:0] s1_chan;
  logic [CW-1:0] s2_chan;
  logic s1_valid;
  logic s2_valid;
  tc_t s1_sum;
  sm_t s2_data;
  sm_t res;
  logic adv1;
  logic adv2;
  logic fire_in;

  assign adv2 = !s2_valid || out_ready;
  assign adv1 = !s1_valid || adv2;
  assign in_ready = adv1 && !rst;
  assign fire_in = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      chan <= '0;
      s1_valid <= 1'b0;
      s1_sum <= '0;
      s1_chan <= '0;
    end else begin
      if (adv1) s1_valid <= fire_in;
      if (fire_in) begin
        s1_sum <= sm_to_tc(in_data) + sm_to_tc(bias_mem[chan]);
        s1_chan <= chan;
        chan <= (chan == LAST) ? '0 : chan + 1'b1;
      end
    end
  end

  sm_sat_add #(.RELU(RELU)) u_sat (
    .sum(s1_sum),
    .res(res)
  );

  // S2 only reloads when it can move, so a stalled output holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data <= '0;
      s2_chan <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= res;
        s2_chan <= s1_chan;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data = s2_data;
  assign out_chan = s2_chan;
  assign pixel_done = s2_valid && out_ready && (s2_chan == LAST);

endmodule

// File: tb/tb_bias_relu_stage.sv
// Scoreboard bench: RELU=0 and RELU=1 instances share one stimulus stream.
module tb_bias_relu_stage;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] bias [0:63];
  logic [15:0] in_data;
  logic in_valid;
  logic out_ready;
  logic in_ready0, in_ready1;
  logic [15:0] od0, od1;
  logic [5:0] oc0, oc1;
  logic ov0, ov1, pd0, pd1;

  always #5 clk = ~clk;

  bias_relu_stage #(.CHANNELS(64), .WIDTH(16), .RELU(1'b0)) u0 (
    .clk(clk), .rst(rst), .bias_mem(bias),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .out_data(od0), .out_chan(oc0), .out_valid(ov0),
    .out_ready(out_ready), .pixel_done(pd0)
  );

  bias_relu_stage #(.CHANNELS(64), .WIDTH(16), .RELU(1'b1)) u1 (
    .clk(clk), .rst(rst), .bias_mem(bias),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_data(od1), .out_chan(oc1), .out_valid(ov1),
    .out_ready(out_ready), .pixel_done(pd1)
  );

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    int ch;
    int cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mchan = 0;
  bit nostall = 1'b1;

  function automatic int sm2i(input logic [15:0] x);
    return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
  endfunction

  function automatic logic [15:0] ref_out(
    input logic [15:0] a,
    input logic [15:0] b,
    input bit relu
  );
    int s;
    s = sm2i(a) + sm2i(b);
    if (s > 32767) s = 32767;
    if (s < -32767) s = -32767;
    if (relu && s < 0) s = 0;
    if (s < 0) return {1'b1, 15'(-s)};
    return {1'b0, 15'(s)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic pd_exp;
    cyc++;
    pd_exp = 1'b0;
    if (ov0 || ov1) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 32'(ov0 | ov1), 32'd0);
      end else begin
        e = q[0];
        chk("valid_r0", 32'(ov0), 32'd1);
        chk("valid_r1", 32'(ov1), 32'd1);
        chk("data_r0", 32'(od0), 32'(e.d0));
        chk("data_r1", 32'(od1), 32'(e.d1));
        chk("chan_r0", 32'(oc0), 32'(e.ch));
        chk("chan_r1", 32'(oc1), 32'(e.ch));
        if (out_ready) begin
          if (nostall) chk("latency", 32'(cyc - e.cyc), 32'd2);
          pd_exp = (e.ch == 63);
          void'(q.pop_front());
        end
      end
    end
    chk("pixel_done_r0", 32'(pd0), 32'(pd_exp));
    chk("pixel_done_r1", 32'(pd1), 32'(pd_exp));
    if (rst) begin
      chk("in_ready_in_rst_r0", 32'(in_ready0), 32'd0);
      chk("in_ready_in_rst_r1", 32'(in_ready1), 32'd0);
      q.delete();
      mchan = 0;
    end else if (in_valid && in_ready0) begin
      q.push_back('{d0: ref_out(in_data, bias[mchan], 1'b0),
                    d1: ref_out(in_data, bias[mchan], 1'b1),
                    ch: mchan, cyc: cyc});
      mchan = (mchan + 1) % 64;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    in_data = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int acc;
    bit got;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) bias[i] = 16'($urandom);
    bias[0] = 16'h8090;
    bias[1] = 16'h8090;
    bias[2] = 16'h7FFF;
    bias[3] = 16'hFFFF;
    bias[4] = 16'h8000;
    bias[5] = 16'h0005;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_out_data", 32'(od0), 32'd0);
    chk("rst_out_chan", 32'(oc0), 32'd0);
    chk("rst_pixel_done", 32'(pd0), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst_r0", 32'(in_ready0), 32'd1);
    chk("in_ready_after_rst_r1", 32'(in_ready1), 32'd1);
    @(posedge clk);
    #1;

    // directed: basic add, clamp, saturation, negative zero
    send(16'h0100);
    send(16'h0010);
    send(16'h7FFF);
    send(16'hFFFF);
    send(16'h8000);
    send(16'h8005);
    drain();

    // full pixel with wrap, back to back
    do_reset();
    for (int i = 0; i < 130; i++) send(16'($urandom));
    drain();

    // backpressure from an empty pipe
    nostall = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    in_data = 16'($urandom);
    repeat (5) begin
      @(negedge clk);
      got = in_ready0;
      if (got) acc++;
      @(posedge clk);
      #1;
      if (got) in_data = 16'($urandom);
    end
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_in_ready_low", 32'(in_ready0), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // random valid/ready traffic
    repeat (300) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data = 16'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    nostall = 1'b1;

    // reset after channel 20
    do_reset();
    for (int i = 0; i <= 20; i++) send(16'($urandom));
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid_r0", 32'(ov0), 32'd0);
    chk("post_rst_valid_r1", 32'(ov1), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk);
    #1;
    send(16'h0100);
    send(16'($urandom));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
